// File: rtl/memory_game_ctrl_pkg.sv
// Shared types and default sizes for the memory-game round sequencer.
package memory_game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_HOLD,
      ST_CLEAR,
      ST_RECALL,
      ST_DONE
   } game_state_e;

   localparam int GAME_DW        = 10;
   localparam int GAME_AW        = 4;
   localparam int GAME_ROUND_LEN = 10;

endpackage

// File: rtl/memory_game_ctrl_if.sv
// Register-file port bundle: the controller writes numbers and reads them back.
interface memory_game_ctrl_if #(
   parameter int DW = 10,
   parameter int AW = 4
) ();

   logic          we;
   logic [AW-1:0] wn;
   logic [DW-1:0] wdata;
   logic [AW-1:0] rn;
   logic [DW-1:0] rdata;

   modport master (output we, output wn, output wdata, output rn, input rdata);
   modport slave  (input we, input wn, input wdata, input rn, output rdata);

endinterface

// File: rtl/memory_game_ctrl_show_timer.sv
// Counts game ticks while a number is on display; hit flags the tick that completes it.
module show_timer #(
   parameter int SHOW_TICKS = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic inc,
   output logic hit
);

   localparam int CW = $clog2(SHOW_TICKS + 1);
   localparam logic [CW-1:0] LAST = CW'(SHOW_TICKS - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc)
         count_d = count_q + 1'b1;
   end

   assign hit = inc && !clr && (count_q == LAST);

   always_ff @(posedge clk) begin
      if (!resetn)
         count_q <= '0;
      else
         count_q <= count_d;
   end

endmodule

// File: rtl/memory_game_ctrl.sv
// Round sequencer: shows ROUND_LEN random numbers, then scores the player's recall.
module memory_game_ctrl
   import memory_game_pkg::*;
#(
   parameter int DW         = GAME_DW,
   parameter int AW         = GAME_AW,
   parameter int ROUND_LEN  = GAME_ROUND_LEN,
   parameter int SHOW_TICKS = 2
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                tick,
   input  logic                start_key,
   input  logic                confirm_key,
   input  logic [DW-1:0]       randnum,
   input  logic [DW-1:0]       sw,
   memory_game_ctrl_if.master  rf,
   output logic [DW-1:0]       led,
   output logic [AW:0]         score,
   output logic                busy,
   output logic                done,
   output logic                pass
);

   localparam logic [AW-1:0] LAST_IDX = AW'(ROUND_LEN - 1);
   localparam logic [AW:0]   FULL     = (AW+1)'(ROUND_LEN);

   game_state_e   state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW:0]   score_q, score_d;
   logic          we_q, we_d;
   logic [AW-1:0] wn_q, wn_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [AW-1:0] rn_q, rn_d;
   logic [DW-1:0] led_q, led_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic          hold_hit;

   show_timer #(.SHOW_TICKS(SHOW_TICKS)) u_show_timer (
      .clk    (clk),
      .resetn (resetn),
      .clr    (state_q != ST_HOLD),
      .inc    (tick && (state_q == ST_HOLD)),
      .hit    (hold_hit)
   );

   always_ff @(posedge clk) begin
      if (!resetn)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start_key) state_d = ST_WRITE;
         ST_WRITE:  state_d = ST_HOLD;
         ST_HOLD:   if (hold_hit) state_d = (idx_q == LAST_IDX) ? ST_CLEAR : ST_WRITE;
         ST_CLEAR:  state_d = ST_RECALL;
         ST_RECALL: if (confirm_key && (idx_q == LAST_IDX)) state_d = ST_DONE;
         ST_DONE:   if (start_key) state_d = ST_WRITE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed from the upcoming state so the registered values line up with it.
   always_comb begin
      idx_d   = idx_q;
      score_d = score_q;
      we_d    = 1'b0;
      wn_d    = wn_q;
      wdata_d = wdata_q;
      led_d   = led_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_key) begin
               idx_d   = '0;
               score_d = '0;
            end
         end
         ST_WRITE: begin
            we_d    = 1'b1;
            wn_d    = idx_q;
            wdata_d = randnum;
            led_d   = randnum;
         end
         ST_HOLD: begin
            if (hold_hit && (idx_q != LAST_IDX))
               idx_d = idx_q + 1'b1;
         end
         ST_CLEAR: idx_d = '0;
         ST_RECALL: begin
            if (confirm_key) begin
               if (sw == rf.rdata)
                  score_d = score_q + 1'b1;
               if (idx_q != LAST_IDX)
                  idx_d = idx_q + 1'b1;
            end
         end
         default: ;
      endcase

      busy_d = (state_d == ST_WRITE) || (state_d == ST_HOLD) ||
               (state_d == ST_CLEAR) || (state_d == ST_RECALL);
      done_d = (state_d == ST_DONE);
      pass_d = done_d && (score_d == FULL);
      rn_d   = (state_d == ST_RECALL) ? idx_d : '0;

      case (state_d)
         ST_IDLE, ST_CLEAR, ST_RECALL: led_d = '0;
         ST_DONE:  led_d = pass_d ? '1 : '0;
         ST_WRITE: if (state_q != ST_HOLD) led_d = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         idx_q   <= '0;
         score_q <= '0;
         we_q    <= 1'b0;
         wn_q    <= '0;
         wdata_q <= '0;
         rn_q    <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         score_q <= score_d;
         we_q    <= we_d;
         wn_q    <= wn_d;
         wdata_q <= wdata_d;
         rn_q    <= rn_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign rf.we    = we_q;
   assign rf.wn    = wn_q;
   assign rf.wdata = wdata_q;
   assign rf.rn    = rn_q;
   assign led      = led_q;
   assign score    = score_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl with a 3-number round and a modelled register file.
module tb_memory_game_ctrl;

   localparam int DW = 10;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          tick = 1'b0;
   logic          start_key = 1'b0;
   logic          confirm_key = 1'b0;
   logic [DW-1:0] randnum = '0;
   logic [DW-1:0] sw = '0;
   logic [DW-1:0] led;
   logic [AW:0]   score;
   logic          busy, done, pass;
   logic [DW-1:0] mem [16];

   int n_checks = 0;
   int n_fail   = 0;

   memory_game_ctrl_if #(.DW(DW), .AW(AW)) rf ();

   memory_game_ctrl #(.DW(DW), .AW(AW), .ROUND_LEN(3), .SHOW_TICKS(2)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .tick        (tick),
      .start_key   (start_key),
      .confirm_key (confirm_key),
      .randnum     (randnum),
      .sw          (sw),
      .rf          (rf.master),
      .led         (led),
      .score       (score),
      .busy        (busy),
      .done        (done),
      .pass        (pass)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rf.we) mem[rf.wn] <= rf.wdata;
   assign rf.rdata = mem[rf.rn];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_we"}, rf.we, 0);
      check({tag, "_wn"}, rf.wn, 0);
      check({tag, "_wdata"}, rf.wdata, 0);
      check({tag, "_rn"}, rf.rn, 0);
      check({tag, "_led"}, led, 0);
      check({tag, "_score"}, score, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
   endtask

   // Precondition: DUT is in its WRITE cycle for index 0.
   task automatic show_round(input logic [DW-1:0] v0, input logic [DW-1:0] v1, input logic [DW-1:0] v2);
      logic [DW-1:0] v [3];
      v = '{v0, v1, v2};
      for (int i = 0; i < 3; i++) begin
         randnum = v[i];
         confirm_key = 1'b1;
         step();
         confirm_key = 1'b0;
         check("we_pulse", rf.we, 1);
         check("wn", rf.wn, i);
         check("wdata", rf.wdata, v[i]);
         check("led_write", led, v[i]);
         check("score_show", score, 0);
         randnum = ~v[i];
         start_key = 1'b1;
         step();
         start_key = 1'b0;
         check("we_drop", rf.we, 0);
         check("led_hold0", led, v[i]);
         check("wn_hold", rf.wn, i);
         pulse_tick();
         check("led_hold1", led, v[i]);
         pulse_tick();
         if (i < 2) begin
            check("led_hold2", led, v[i]);
            check("we_idle_hold", rf.we, 0);
         end else begin
            check("led_clear", led, 0);
            check("busy_clear", busy, 1);
         end
      end
      step();
      check("rn_first", rf.rn, 0);
      check("led_recall", led, 0);
   endtask

   task automatic recall_round(input logic [DW-1:0] a0, input logic [DW-1:0] a1, input logic [DW-1:0] a2,
                               input int s0, input int s1, input int s2);
      logic [DW-1:0] a [3];
      int s [3];
      a = '{a0, a1, a2};
      s = '{s0, s1, s2};
      for (int i = 0; i < 3; i++) begin
         pulse_tick();
         check("rn_tick_ignored", rf.rn, i);
         sw = a[i];
         confirm_key = 1'b1;
         step();
         confirm_key = 1'b0;
         check("score_step", score, s[i]);
         if (i < 2) check("rn_next", rf.rn, i + 1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      step();
      step();
      check_all_zero("reset");
      resetn = 1'b1;
      step();
      check("idle_busy", busy, 0);

      // Round 1: all answers correct
      randnum = 10'h005;
      start_key = 1'b1;
      step();
      start_key = 1'b0;
      check("write_busy", busy, 1);
      check("write_we", rf.we, 0);
      show_round(10'h005, 10'h00A, 10'h3FF);
      recall_round(10'h005, 10'h00A, 10'h3FF, 1, 2, 3);
      check("r1_done", done, 1);
      check("r1_pass", pass, 1);
      check("r1_led", led, 10'h3FF);
      check("r1_busy", busy, 0);

      // Round 2: wrong answer at index 1
      start_key = 1'b1;
      step();
      start_key = 1'b0;
      check("r2_done_drop", done, 0);
      check("r2_pass_drop", pass, 0);
      check("r2_score_clr", score, 0);
      show_round(10'h005, 10'h00A, 10'h3FF);
      recall_round(10'h005, 10'h00B, 10'h3FF, 1, 1, 2);
      check("r2_done", done, 1);
      check("r2_pass", pass, 0);
      check("r2_led", led, 0);
      check("r2_score", score, 2);

      // Round 3: start and confirm together in DONE, then reset mid-recall
      sw = 10'h3FF;
      start_key = 1'b1;
      confirm_key = 1'b1;
      step();
      start_key = 1'b0;
      confirm_key = 1'b0;
      check("r3_done_drop", done, 0);
      check("r3_score_clr", score, 0);
      check("r3_busy", busy, 1);
      show_round(10'h123, 10'h2AA, 10'h001);
      sw = 10'h123;
      confirm_key = 1'b1;
      step();
      confirm_key = 1'b0;
      check("r3_score1", score, 1);
      check("r3_rn1", rf.rn, 1);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      check_all_zero("midreset");
      randnum = 10'h155;
      start_key = 1'b1;
      step();
      start_key = 1'b0;
      check("r4_score", score, 0);
      check("r4_busy", busy, 1);
      step();
      check("r4_we", rf.we, 1);
      check("r4_wn", rf.wn, 0);
      check("r4_wdata", rf.wdata, 10'h155);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_game_ctrl.md
Name: memory_game_ctrl

Overview:
Round sequencer for the memory game. It drives the show phase: it samples ROUND_LEN random numbers, writes each into the game register file and displays it on the LEDs for SHOW_TICKS game ticks. It then drives the recall phase: it reads each stored entry back, compares it with the player's switch value on every confirm press, and reports the score and pass/fail. It sits between the random generator, the register file and the board I/O (keys, switches, LEDs).

Parameters:
DW, 10, data width of numbers, LEDs and switches
AW, 4, register-file address width
ROUND_LEN, 10, numbers per round (2 ≤ ROUND_LEN ≤ 2^AW)
SHOW_TICKS, 2, tick pulses each number stays on the LEDs (≥ 1)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
tick  in  1  one-cycle game-timing pulse, derived from the game clock divider
start_key  in  1  one-cycle start pulse, already debounced
confirm_key  in  1  one-cycle confirm pulse, already debounced
randnum  in  DW  random-generator output
sw  in  DW  player switch input
rdata  in  DW  register-file read data (combinational on rn)
we  out  1  register-file write enable
wn  out  AW  write address
wdata  out  DW  write data
rn  out  AW  read address
led  out  DW  LED drive
score  out  AW+1  count of correct answers in the current round
busy  out  1  high in SHOW, CLEAR and RECALL
done  out  1  high in DONE
pass  out  1  high in DONE when score == ROUND_LEN

Behaviour:
- Clock and reset: only clk is used. While resetn=0 at a clk edge: state=IDLE and all outputs 0 (we, wn, wdata, rn, led, score, busy, done, pass), idx=0, hold=0. Reset wins over every other event, including mid-round.
- States are IDLE, WRITE, HOLD, CLEAR, RECALL, DONE. All outputs are registered.
- IDLE: led=0, we=0. A start_key pulse moves to WRITE with idx=0, score=0.
- WRITE (exactly 1 cycle):
  - we=1, wn=idx, wdata=randnum sampled this cycle; led shows the same value from the next cycle on.
  - Moves to HOLD with hold=0. A tick in WRITE is not counted.
- HOLD: we=0, led keeps the value just written. Each tick increments hold.
  - When the tick makes hold reach SHOW_TICKS: if idx==ROUND_LEN-1, go to CLEAR; else idx+1 and go to WRITE.
  - Time per number is therefore 1 cycle plus SHOW_TICKS ticks.
- CLEAR (1 cycle): led=0, idx=0, then RECALL.
- RECALL: rn=idx, led=0.
  - A confirm_key pulse compares sw with rdata in that cycle; on equality score+1 (saturating cannot occur because score ≤ ROUND_LEN).
  - If idx==ROUND_LEN-1, go to DONE; else idx+1 and stay in RECALL.
  - With no confirm, wait indefinitely.
- DONE: done=1, pass=(score==ROUND_LEN), led = all-ones if pass else 0. A start_key pulse goes to WRITE with idx=0, score=0; done and pass drop the next cycle.
- Ignored inputs:
  - start_key outside IDLE/DONE is ignored; it does not restart a round.
  - confirm_key outside RECALL is ignored.
  - tick outside HOLD is ignored.
- Simultaneous start_key and confirm_key in DONE: start wins.
- Addresses: wn and rn never exceed ROUND_LEN-1. idx wraps to 0 only through CLEAR or a restart.
- randnum is sampled only in WRITE; it may change freely at other times.

Decomposition:
- Package memory_game_pkg holds:
  - the state enum (IDLE, WRITE, HOLD, CLEAR, RECALL, DONE);
  - default constants GAME_DW=10, GAME_AW=4, GAME_ROUND_LEN=10.
- Sub-module show_timer: tick counter with clear and terminal-count flag, width $clog2(SHOW_TICKS+1). It is instantiated once for HOLD.
- FSM, idx counter and scoring stay in the top.

Test Plan:
1. ROUND_LEN=3, SHOW_TICKS=2; start, randnum=0x005,0x00A,0x3FF at the WRITE cycles -> we pulses with (wn,wdata)=(0,0x005),(1,0x00A),(2,0x3FF); led holds each value until the 2nd tick after its write; led=0 in CLEAR.
2. Same round; confirm three times with sw equal to stored values, rdata modelled by a register file -> rn steps 0,1,2; score=3; done=1, pass=1, led=0x3FF.
3. Same round; wrong sw on index 1 -> score=2, pass=0, led=0 in DONE.
4. start_key during HOLD and confirm_key during WRITE/HOLD -> no state, score or address change; ticks in RECALL do not advance idx.
5. resetn=0 for one clk in the middle of RECALL at idx=1 -> next cycle IDLE with all outputs 0; a following start begins at wn=0, score=0.
6. Start and confirm in the same cycle in DONE -> WRITE entered, score=0, wn=0, done=0 the next cycle.
